// File: rtl/pc_gen.sv
// Program-counter generator: next-PC selection with priority redirects, hold handling,
// a latched pending redirect, target alignment trapping and a one-cycle boot state.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(32'h0000_0380),
    parameter int              INC       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            if_ready,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jr_valid,
    input  logic [XLEN-1:0] jr_target,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    input  logic            exc_req,
    input  logic            eret,
    input  logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus,
    output logic            if_valid,
    output logic            redirect_pend,
    output logic            addr_err,
    output logic [XLEN-1:0] bad_vaddr
);

    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    typedef enum logic {BOOT, RUN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] ptgt_q, ptgt_d;
    logic            addr_err_q, addr_err_d;
    logic [XLEN-1:0] bad_vaddr_q, bad_vaddr_d;

    logic            hold;
    logic            redir;
    logic [XLEN-1:0] redir_tgt;
    logic            apply;
    logic [XLEN-1:0] apply_tgt;

    assign pc_plus = pc_q + INC_V;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        ptgt_d      = ptgt_q;
        addr_err_d  = 1'b0;
        bad_vaddr_d = bad_vaddr_q;
        hold        = stall | ~if_ready;
        redir       = branch_taken | jr_valid | jump_valid;
        apply       = 1'b0;
        apply_tgt   = '0;

        // EX-stage redirects are older than the ID-stage jump, so they win
        if (branch_taken)    redir_tgt = branch_target;
        else if (jr_valid)   redir_tgt = jr_target;
        else                 redir_tgt = jump_target;

        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (exc_req) begin
            pc_d   = EXC_VEC;
            pend_d = 1'b0;
        end else begin
            if (eret) begin
                apply     = 1'b1;
                apply_tgt = epc;
            end else if (redir && hold) begin
                pend_d = 1'b1;
                ptgt_d = redir_tgt;
            end else if (redir) begin
                apply     = 1'b1;
                apply_tgt = redir_tgt;
            end else if (pend_q && !hold) begin
                apply     = 1'b1;
                apply_tgt = ptgt_q;
            end else if (!hold) begin
                pc_d = pc_plus;
            end

            // Alignment is checked only when a target is actually applied
            if (apply) begin
                pend_d = 1'b0;
                if ((apply_tgt & ALIGN_MASK) != '0) begin
                    pc_d        = EXC_VEC;
                    addr_err_d  = 1'b1;
                    bad_vaddr_d = apply_tgt;
                end else begin
                    pc_d = apply_tgt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            pend_q      <= 1'b0;
            ptgt_q      <= '0;
            addr_err_q  <= 1'b0;
            bad_vaddr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            ptgt_q      <= ptgt_d;
            addr_err_q  <= addr_err_d;
            bad_vaddr_q <= bad_vaddr_d;
        end
    end

    assign pc_out        = pc_q;
    assign if_valid      = (state_q == RUN);
    assign redirect_pend = pend_q;
    assign addr_err      = addr_err_q;
    assign bad_vaddr     = bad_vaddr_q;

endmodule
